// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit LSB-first UART transmitter with valid/ready intake and registered line output.
// Optional even parity bit between bit 7 and the stop bit when UART_TX_PARITY_EN is defined.
module uart_transmitter #(
    parameter logic [13:0] BAUD_RATE_NUMBER = 14'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state, state_d;
    logic [13:0] timer, timer_d;
    logic [2:0]  idx, idx_d;
    logic [7:0]  shift, shift_d;
    logic        tx_d;
    logic        tick;
`ifdef UART_TX_PARITY_EN
    logic        par, par_d;
`endif

    assign tick     = timer == 14'd0;
    assign tx_ready = state == IDLE;
    assign tx_busy  = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            timer <= BAUD_RATE_NUMBER;
            idx   <= 3'd0;
            shift <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            tx    <= tx_d;
            timer <= timer_d;
            idx   <= idx_d;
            shift <= shift_d;
`ifdef UART_TX_PARITY_EN
            par   <= par_d;
`endif
        end
    end

    // tx is registered from the next state so the line changes on the same edge as the state
    always_comb begin
        state_d = state;
        idx_d   = idx;
        shift_d = shift;
        timer_d = tick ? BAUD_RATE_NUMBER : timer - 14'd1;
`ifdef UART_TX_PARITY_EN
        par_d   = par;
`endif
        case (state)
            IDLE: begin
                timer_d = BAUD_RATE_NUMBER;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            START: state_d = tick ? DATA : START;
            DATA: if (tick) begin
                shift_d = shift >> 1;
                idx_d   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                state_d = (idx == 3'd7) ? PARITY : DATA;
`else
                state_d = (idx == 3'd7) ? STOP : DATA;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_d = tick ? STOP : PARITY;
`endif
            STOP: state_d = tick ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_PARITY_EN
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`endif
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of uart_transmitter at P=4, P=2 and P=16384.
module tb_uart_transmitter;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 11;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       ready0, tx0, busy0;
    logic       ready1, tx1, busy1;
    logic       ready2, tx2, busy2;
    int         checks = 0;
    int         errors = 0;
    int         n;

    always #5 clk = ~clk;

    uart_transmitter #(.BAUD_RATE_NUMBER(14'd3)) u_dut (
        .clk(clk), .rst(rst), .tx_data(d0), .tx_valid(v0), .tx_ready(ready0), .tx(tx0), .tx_busy(busy0)
    );
    uart_transmitter #(.BAUD_RATE_NUMBER(14'd1)) u_p2 (
        .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(ready1), .tx(tx1), .tx_busy(busy1)
    );
    uart_transmitter #(.BAUD_RATE_NUMBER(14'd16383)) u_pmax (
        .clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(ready2), .tx(tx2), .tx_busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected line level for frame bit b: start, d[0..7], optional parity, stop
    function automatic logic bitval(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR && b == 9) return ^d;
        return 1'b1;
    endfunction

    // called right after the accept edge; ends right after the edge that returns to idle
    task automatic check_frame(input logic [7:0] d, input bit poke);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("tx d=%0h bit%0d", d, b), tx0, bitval(d, b));
                chk("busy in frame", busy0, 1);
                chk("ready in frame", ready0, 0);
                if (poke && b * 4 + c == 10) begin
                    v0 = 1'b1;
                    d0 = 8'h3C;
                end
                if (poke && b * 4 + c == 14) v0 = 1'b0;
                if (poke && b * 4 + c == 20) d0 = 8'h5A;
                step();
            end
        end
        chk("tx after frame", tx0, 1);
        chk("busy after frame", busy0, 0);
        chk("ready after frame", ready0, 1);
    endtask

    initial begin
        rst = 1'b0;
        {v0, v1, v2} = 3'b000;
        {d0, d1, d2} = 24'h0;
        repeat (3) step();
        chk("reset tx", tx0, 1);
        chk("reset ready", ready0, 1);
        chk("reset busy", busy0, 0);
        rst = 1'b1;
        repeat (2) step();
        chk("idle tx", tx0, 1);

        d0 = 8'hA5; v0 = 1'b1; step(); v0 = 1'b0;
        check_frame(8'hA5, 1'b0);
        d0 = 8'h01; v0 = 1'b1; step(); v0 = 1'b0;
        check_frame(8'h01, 1'b0);

        // valid held high: second frame starts one idle cycle after the first ends
        d0 = 8'h00; v0 = 1'b1; step(); d0 = 8'hFF;
        check_frame(8'h00, 1'b0);
        step(); v0 = 1'b0;
        check_frame(8'hFF, 1'b0);

        d0 = 8'h81; v0 = 1'b1; step(); v0 = 1'b0;
        check_frame(8'h81, 1'b1);
        repeat (3) begin
            chk("no late accept tx", tx0, 1);
            chk("no late accept busy", busy0, 0);
            step();
        end

        d0 = 8'hA5; v0 = 1'b1; step(); v0 = 1'b0;
        repeat (10) step();
        chk("pre-abort tx", tx0, 0);
        rst = 1'b0;
        #1;
        chk("abort tx", tx0, 1);
        chk("abort ready", ready0, 1);
        chk("abort busy", busy0, 0);
        repeat (5) begin
            step();
            chk("in reset tx", tx0, 1);
            chk("in reset busy", busy0, 0);
        end
        rst = 1'b1;
        repeat (5) begin
            step();
            chk("post reset tx", tx0, 1);
            chk("post reset busy", busy0, 0);
        end
        d0 = 8'h5A; v0 = 1'b1; step(); v0 = 1'b0;
        check_frame(8'h5A, 1'b0);

        d1 = 8'h55; v1 = 1'b1; step(); v1 = 1'b0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("p2 tx bit%0d", b), tx1, bitval(8'h55, b));
                chk("p2 busy", busy1, 1);
                step();
            end
        end
        chk("p2 busy end", busy1, 0);
        chk("p2 ready end", ready1, 1);

        // 0x02: start+bit0 low for two periods, then bit1 high for one
        d2 = 8'h02; v2 = 1'b1; step(); v2 = 1'b0;
        chk("pmax start", tx2, 0);
        n = 0;
        while (tx2 == 1'b0 && n < 40000) begin
            step();
            n++;
        end
        chk("pmax low run", n, 32768);
        n = 0;
        while (tx2 == 1'b1 && n < 20000) begin
            step();
            n++;
        end
        chk("pmax high run", n, 16384);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial 8-bit UART transmitter, the transmit-side counterpart of the lab's UART receiver path. Accepts a byte over a valid/ready handshake and shifts it out LSB-first on a single registered line as an asynchronous frame: start bit, 8 data bits, optional parity, stop bit. It uses an internal down-counting bit-period timer with the same reload convention as the design's baud rate generator, so a given `BAUD_RATE_NUMBER` produces the same bit period on both ends of the link.

## Interface
- `BAUD_RATE_NUMBER`, 14'd20, timer reload value; bit period = `BAUD_RATE_NUMBER`+1 clk cycles; legal range 1..16383.

- `clk`  input  1  system clock, all state on rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `tx_data`  input  8  byte to send; sampled only on the accept edge.
- `tx_valid`  input  1  byte on `tx_data` is offered.
- `tx_ready`  output  1  high only in IDLE; a byte is accepted on a rising edge where `tx_valid` && `tx_ready`.
- `tx`  output  1  serial line, registered, idle high.
- `tx_busy`  output  1  high from the cycle after accept until the frame's last stop-bit cycle, inclusive.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- Reset (`rst` low, async): state IDLE, `tx`=1, `tx_ready`=1, `tx_busy`=0, timer=`BAUD_RATE_NUMBER`, bit index=0, shift register=0. While `rst` is low no handshake is accepted.
- IDLE: `tx`=1. On accept, latch `tx_data` into the shift register, load timer with `BAUD_RATE_NUMBER`, go to START.
- Timer: 14-bit down-counter. Bit tick = (timer==0). On tick, reload `BAUD_RATE_NUMBER`; otherwise decrement. The timer is reloaded on accept, so every frame starts phase-aligned (no carry-over from idle time).
- START: `tx`=0 for one bit period; on tick go to DATA.
- DATA: `tx`=shift[0]; on tick shift right, increment 3-bit bit index; after the tick with index 7, go to PARITY if enabled, else STOP.
- PARITY: `tx`=even parity (XOR of the 8 latched data bits); on tick go to STOP.
- STOP: `tx`=1 for one bit period; on tick go to IDLE.
- `tx_data`/`tx_valid` changes outside the accept edge have no effect; `tx_valid` while busy is held off (`tx_ready`=0), never dropped internally.
- Reset mid-frame: frame aborts immediately; `tx` returns to 1 asynchronously; no partial resumption after release.

## Timing
- Let P = `BAUD_RATE_NUMBER`+1. Accept at edge E. `tx` falls at E+1 (registered output) and holds 0 for P cycles.
- Data bit k (LSB first) drives `tx` for cycles E+1+P·(1+k) through E+P·(2+k).
- Frame length F = 10·P cycles (11·P with parity). `tx_busy` high for cycles E+1 .. E+F.
- Return to IDLE at edge E+F+1 (= E+1+F); `tx_ready` high from that cycle. Earliest next accept is at that edge, so back-to-back frames have exactly one extra idle-high cycle (stop bit length P+1 on the line).
- `tx_ready` is a pure decode of state (no combinational path from `tx_valid`).
- `BAUD_RATE_NUMBER`=1 gives P=2; no special case.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in, even parity bit inserted between bit 7 and the stop bit, frame 11·P cycles.
- Not defined: PARITY state and parity logic absent; frame is 8N1, 10·P cycles; DATA goes directly to STOP.

## Test plan
- Reset: hold `rst` low 5 cycles mid-frame -> `tx`=1, `tx_ready`=1, `tx_busy`=0 immediately; after release, line idle high until next accept.
- `BAUD_RATE_NUMBER`=3, send 0xA5 (no macro) -> `tx` sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1; `tx_busy` high exactly 40 cycles; `tx_ready` returns 41 cycles after accept edge.
- Same with `UART_TX_PARITY_EN`, send 0xA5 -> parity bit 0, frame 44 cycles; send 0x01 -> parity bit 1.
- Back-to-back: `tx_valid` held high with 0x00 then 0xFF -> second start bit falls exactly 41 cycles after first (P=4, one extra idle cycle), second frame all-ones data.
- Handshake hold-off: pulse `tx_valid` with 0x3C during a frame and change `tx_data` mid-frame -> no acceptance while busy; in-flight bits unaffected.
- `BAUD_RATE_NUMBER`=1 and 14'd16383 -> bit periods of 2 and 16384 cycles, measured on every bit of one frame.
